// File: rtl/fpmul_round_pack_if.sv
// Operand/product input handshake and packed-result output handshake of the FP32 multiply round/pack stage.
// The master side drives operands and out_ready; the slave side (the stage) answers with in_ready and results.
interface fpmul_round_pack_if;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [47:0] prod_i;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result_o;
  logic [3:0]  flags_o;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output a_i, b_i, prod_i, in_valid, out_ready,
    input  in_ready, result_o, flags_o, out_valid
  );

  modport slave (
    input  a_i, b_i, prod_i, in_valid, out_ready,
    output in_ready, result_o, flags_o, out_valid
  );
endinterface

// File: rtl/fpmul_round_pack.sv
// FP32 multiply normalize/round/pack: 2 register stages, 1 result/cycle, stalls upstream when out_ready is low.
// FPMUL_RNE_EN selects round-to-nearest-even; left undefined the stage truncates toward zero.
module fpmul_round_pack #(
  parameter int BIAS = 127
) (
  input logic               clk,
  input logic               rst_n,
  fpmul_round_pack_if.slave bus
);

  typedef struct packed {
    logic        sign;
    logic        a_zero;
    logic        a_inf;
    logic        a_nan;
    logic        a_snan;
    logic        b_zero;
    logic        b_inf;
    logic        b_nan;
    logic        b_snan;
    logic [9:0]  es;
    logic [22:0] mant;
    logic        guard;
    logic        sticky;
  } meta_t;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  meta_t       s1_q, s1_d, s1_new;
  logic        s1_valid_q, s1_valid_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;

  logic        s2_adv;
  logic        in_ready;
  logic        in_fire;

  logic [7:0]  ea, eb;
  logic [9:0]  es_sum;

  logic        rnd_up;
  logic [23:0] mant_inc;
  logic [9:0]  es_rnd;
  logic [31:0] res_new;
  logic [3:0]  flg_new;
  logic        any_nan, any_inf, any_zero;

  // Both stages share one advance condition: S2 can take new data whenever it is empty or draining.
  assign s2_adv   = !s2_valid_q || bus.out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_fire  = bus.in_valid && in_ready;

  assign ea = bus.a_i[30:23];
  assign eb = bus.b_i[30:23];

  always_comb begin
    s1_new        = '0;
    s1_new.sign   = bus.a_i[31] ^ bus.b_i[31];
    s1_new.a_zero = (ea == 8'h00);
    s1_new.a_inf  = (ea == 8'hFF) && (bus.a_i[22:0] == 23'd0);
    s1_new.a_nan  = (ea == 8'hFF) && (bus.a_i[22:0] != 23'd0);
    s1_new.a_snan = s1_new.a_nan && !bus.a_i[22];
    s1_new.b_zero = (eb == 8'h00);
    s1_new.b_inf  = (eb == 8'hFF) && (bus.b_i[22:0] == 23'd0);
    s1_new.b_nan  = (eb == 8'hFF) && (bus.b_i[22:0] != 23'd0);
    s1_new.b_snan = s1_new.b_nan && !bus.b_i[22];
    // Two's-complement wrap in 10 bits gives the signed biased sum directly.
    es_sum = {2'b00, ea} + {2'b00, eb} - 10'(BIAS);
    if (bus.prod_i[47]) begin
      s1_new.es     = es_sum + 10'd1;
      s1_new.mant   = bus.prod_i[46:24];
      s1_new.guard  = bus.prod_i[23];
      s1_new.sticky = |bus.prod_i[22:0];
    end else begin
      s1_new.es     = es_sum;
      s1_new.mant   = bus.prod_i[45:23];
      s1_new.guard  = bus.prod_i[22];
      s1_new.sticky = |bus.prod_i[21:0];
    end
  end

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (in_fire) begin
      s1_d       = s1_new;
      s1_valid_d = 1'b1;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

`ifdef FPMUL_RNE_EN
  assign rnd_up = s1_q.guard && (s1_q.sticky || s1_q.mant[0]);
`else
  assign rnd_up = 1'b0;
`endif

  // A carry out of the 23-bit mantissa leaves the low bits zero and bumps the exponent.
  assign mant_inc = {1'b0, s1_q.mant} + {23'd0, rnd_up};
  assign es_rnd   = s1_q.es + {9'd0, mant_inc[23]};

  assign any_nan  = s1_q.a_nan  || s1_q.b_nan;
  assign any_inf  = s1_q.a_inf  || s1_q.b_inf;
  assign any_zero = s1_q.a_zero || s1_q.b_zero;

  always_comb begin
    res_new = '0;
    flg_new = '0;
    if (any_nan) begin
      res_new    = QNAN;
      flg_new[3] = s1_q.a_snan || s1_q.b_snan;
    end else if (any_inf && any_zero) begin
      res_new    = QNAN;
      flg_new[3] = 1'b1;
    end else if (any_inf) begin
      res_new = {s1_q.sign, 8'hFF, 23'd0};
    end else if (any_zero) begin
      res_new = {s1_q.sign, 31'd0};
    end else if ($signed(es_rnd) >= 10'sd255) begin
      res_new = {s1_q.sign, 8'hFF, 23'd0};
      flg_new = 4'b0101;
    end else if ($signed(es_rnd) <= 10'sd0) begin
      res_new = {s1_q.sign, 31'd0};
      flg_new = 4'b0011;
    end else begin
      res_new    = {s1_q.sign, es_rnd[7:0], mant_inc[22:0]};
      flg_new[0] = s1_q.guard || s1_q.sticky;
    end
  end

  always_comb begin
    result_d   = result_q;
    flags_d    = flags_q;
    s2_valid_d = s2_valid_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = res_new;
        flags_d  = flg_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.result_o  = result_q;
  assign bus.flags_o   = flags_q;

endmodule

// File: tb/tb_fpmul_round_pack.sv
// Directed bench for fpmul_round_pack: single products, specials, rounding, a stalled stream and mid-flight reset.
// Build with FPMUL_RNE_EN defined to select the round-to-nearest-even expectations.
module tb_fpmul_round_pack;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  fpmul_round_pack_if bus();

  fpmul_round_pack #(.BIAS(127)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] mk_prod(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] sa, sb;
    sa = {24'd0, 1'b1, a[22:0]};
    sb = {24'd0, 1'b1, b[22:0]};
    return sa * sb;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    bus.a_i      = a;
    bus.b_i      = b;
    bus.prod_i   = mk_prod(a, b);
    bus.in_valid = 1'b1;
  endtask

  // Caller enters just after a rising edge with an empty pipeline.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input logic [3:0] exp_f);
    bus.out_ready = 1'b1;
    drive(a, b);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_result"}, bus.result_o, exp_r);
    check({tag, "_flags"}, 32'(bus.flags_o), 32'(exp_f));
    @(posedge clk); #1;
  endtask

  logic [31:0] sa [4];
  logic [31:0] sb [4];
  logic [31:0] sr [4];
  int in_idx, out_idx;

  initial begin
    bus.a_i = '0; bus.b_i = '0; bus.prod_i = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.result_o, 32'h0);
    check("rst_flags", 32'(bus.flags_o), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    run_one("mul_1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    run_one("mul_1p5sq", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000);
    run_one("tie_even", 32'h3F800800, 32'h3F800800, 32'h3F801000, 4'b0001);
    run_one("sticky_only", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
`ifdef FPMUL_RNE_EN
    run_one("round_up", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001);
`else
    run_one("round_trunc", 32'h3F800001, 32'h3FC00000, 32'h3FC00001, 4'b0001);
`endif
    run_one("overflow", 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
    run_one("max_exp", 32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000);
    run_one("underflow", 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
    run_one("min_exp", 32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000);
    run_one("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    run_one("ninf_x_2", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
    run_one("snan", 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
    run_one("qnan", 32'h40000000, 32'hFFC00000, 32'h7FC00000, 4'b0000);
    run_one("nzero", 32'h80000000, 32'h40000000, 32'h80000000, 4'b0000);
    run_one("subnorm", 32'h00000001, 32'h40000000, 32'h00000000, 4'b0000);

    // Stream of four with the consumer stalled for cycles 2..4.
    sa = '{32'h3F800000, 32'h3FC00000, 32'h3FC00000, 32'h40000000};
    sb = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h40000000};
    sr = '{32'h3F800000, 32'h40400000, 32'h40100000, 32'h40800000};
    in_idx = 0;
    out_idx = 0;
    bus.out_ready = 1'b1;
    drive(sa[0], sb[0]);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 2) begin
        check("stream_accepted", 32'(in_idx), 32'd2);
        check("stream_in_ready_low", 32'(bus.in_ready), 32'd0);
      end
      if (c >= 2 && c <= 4) begin
        check($sformatf("stream_hold_valid%0d", c), 32'(bus.out_valid), 32'd1);
        check($sformatf("stream_hold_data%0d", c), bus.result_o, sr[0]);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (out_idx < 4) begin
          check($sformatf("stream_out%0d", out_idx), bus.result_o, sr[out_idx]);
          check($sformatf("stream_flags%0d", out_idx), 32'(bus.flags_o), 32'h0);
        end
        out_idx++;
      end
      if (bus.in_valid && bus.in_ready) in_idx++;
      @(posedge clk); #1;
      if (in_idx < 4) drive(sa[in_idx], sb[in_idx]);
      else bus.in_valid = 1'b0;
      bus.out_ready = !((c + 1) >= 2 && (c + 1) <= 4);
    end
    check("stream_in_count", 32'(in_idx), 32'd4);
    check("stream_out_count", 32'(out_idx), 32'd4);

    // Fill both stages, then reset mid-flight.
    bus.out_ready = 1'b0;
    drive(32'h3FC00000, 32'h40000000);
    @(posedge clk); #1;
    drive(32'h40000000, 32'h40000000);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("full_out_valid", 32'(bus.out_valid), 32'd1);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_result", bus.result_o, 32'h0);
    check("mid_rst_flags", 32'(bus.flags_o), 32'h0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    run_one("after_rst", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    @(negedge clk);
    check("drained", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
